// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the multiply-sequencer state encoding.
// Used by the execute-stage ALU and by the iterative multiplier built on top of it.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_PASS = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Combinational add/sub/pass ALU of configurable width; zero-latency, no flow control.
// zero flags an all-zero result.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       aluctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (aluctrl)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_PASS: result = op2;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Unsigned DATA_WIDTH x DATA_WIDTH shift-add multiplier, one partial product per cycle
// through a private ALU; result valid DATA_WIDTH cycles after accept and held until resp_ready.
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    mul_state_t            state;
    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [CW-1:0]         count_q;

    // One extra ALU bit keeps the carry of each accumulate step.
    logic [DATA_WIDTH:0]   alu_op1;
    logic [DATA_WIDTH:0]   alu_op2;
    logic [DATA_WIDTH:0]   alu_sum;
    logic                  alu_zero_unused;

    assign alu_op1 = {1'b0, hi_q};
    assign alu_op2 = lo_q[0] ? {1'b0, mcand_q} : '0;

    alu #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_alu (
        .op1     (alu_op1),
        .op2     (alu_op2),
        .aluctrl (ALU_ADD),
        .result  (alu_sum),
        .zero    (alu_zero_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            count_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mcand_q   <= multiplicand;
                        lo_q      <= multiplier;
                        hi_q      <= '0;
                        count_q   <= '0;
                        req_ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // 65-bit right shift of carry:sum:lo; consumed multiplier bits fall off lo.
                    hi_q    <= alu_sum[DATA_WIDTH:1];
                    lo_q    <= {alu_sum[0], lo_q[DATA_WIDTH-1:1]};
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign result_lo = lo_q;
    assign result_hi = hi_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner products plus random
// back-to-back pairs against a 64-bit arithmetic reference.
module tb_mul_sequencer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] multiplicand = '0;
    logic [DW-1:0] multiplier = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] result_lo;
    logic [DW-1:0] result_hi;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int accept_cyc = 0;

    mul_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .result_lo    (result_lo),
        .result_hi    (result_hi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake outputs must never both be high.
    always @(negedge clk) begin
        if (req_ready === 1'b1 || resp_valid === 1'b1) begin
            checks++;
            if (req_ready === 1'b1 && resp_valid === 1'b1) begin
                failures++;
                $display("FAIL ready_valid_exclusive got req_ready=1 resp_valid=1 want not both at cycle %0d", cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its response; lat = edges from accept to resp_valid, -1 on timeout.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int lat, output logic [2*DW-1:0] prod);
        int n;
        req_valid    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tick();
        accept_cyc = cyc;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        if (resp_valid !== 1'b1 || n >= 100) lat = -1;
        prod = {result_hi, result_lo};
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result_lo !== '0 || result_hi !== '0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b vld=%b lo=%h hi=%h want rdy=1 vld=0 lo=0 hi=0",
                     req_ready, resp_valid, result_lo, result_hi);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [2*DW-1:0] prod;
        run_op(32'd3, 32'd5, lat, prod);
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=32", lat);
        end
        checks++;
        if (prod[DW-1:0] !== 32'h0000000F || prod[2*DW-1:DW] !== 32'h0) begin
            failures++;
            $display("FAIL basic_3x5 got hi=%h lo=%h want hi=00000000 lo=0000000f", prod[2*DW-1:DW], prod[DW-1:0]);
        end
        release_resp();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_release got rdy=%b vld=%b want rdy=1 vld=0", req_ready, resp_valid);
        end
    endtask

    task automatic test_corners();
        logic [DW-1:0] ta [4];
        logic [DW-1:0] tb [4];
        logic [DW-1:0] elo [4];
        logic [DW-1:0] ehi [4];
        int lat;
        logic [2*DW-1:0] prod;
        ta[0] = 32'hFFFFFFFF; tb[0] = 32'hFFFFFFFF; elo[0] = 32'h00000001; ehi[0] = 32'hFFFFFFFE;
        ta[1] = 32'h80000000; tb[1] = 32'd2;        elo[1] = 32'h00000000; ehi[1] = 32'h00000001;
        ta[2] = 32'h0;        tb[2] = 32'h12345678; elo[2] = 32'h00000000; ehi[2] = 32'h00000000;
        ta[3] = 32'h12345678; tb[3] = 32'h0;        elo[3] = 32'h00000000; ehi[3] = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], lat, prod);
            checks++;
            if (prod[DW-1:0] !== elo[i] || prod[2*DW-1:DW] !== ehi[i] || lat !== 32) begin
                failures++;
                $display("FAIL corner_%0d got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=32",
                         i, prod[2*DW-1:DW], prod[DW-1:0], lat, ehi[i], elo[i]);
            end
            release_resp();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2*DW-1:0] prod;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2*DW-1:0] expv;
        a = $urandom;
        b = $urandom;
        expv = 64'(a) * 64'(b);
        run_op(a, b, lat, prod);
        checks++;
        if (prod !== expv || lat !== 32) begin
            failures++;
            $display("FAIL bp_product got=%h lat=%0d want=%h lat=32", prod, lat, expv);
        end
        for (int i = 0; i < 10; i++) begin
            req_valid    = i[0];
            multiplicand = $urandom;
            multiplier   = $urandom;
            tick();
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || {result_hi, result_lo} !== expv) begin
                failures++;
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h",
                         i, resp_valid, req_ready, {result_hi, result_lo}, expv);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_early got=%b want=0", req_ready);
        end
        tick();
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic [2*DW-1:0] prod;
        req_valid    = 1'b1;
        multiplicand = 32'hDEADBEEF;
        multiplier   = 32'hCAFEF00D;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result_lo !== '0 || result_hi !== '0) begin
            failures++;
            $display("FAIL midrun_reset got rdy=%b vld=%b lo=%h hi=%h want rdy=1 vld=0 lo=0 hi=0",
                     req_ready, resp_valid, result_lo, result_hi);
        end
        // Request presented together with reset must be dropped.
        req_valid = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_beats_req got rdy=%b want=1", req_ready);
        end
        run_op(32'd7, 32'd6, lat, prod);
        checks++;
        if (prod !== 64'd42 || lat !== 32) begin
            failures++;
            $display("FAIL after_reset_7x6 got=%0d lat=%0d want=42 lat=32", prod, lat);
        end
        release_resp();
    endtask

    task automatic test_back_to_back();
        logic [2*DW-1:0] model_q [$];
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2*DW-1:0] expv;
        logic [2*DW-1:0] prod;
        int lat;
        int prev_accept;
        int bad_prod = 0;
        int bad_lat = 0;
        int bad_gap = 0;
        prev_accept = -1000;
        resp_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 8)
                0: a = '1;
                1: b = '1;
                2: a = 32'h1 << (i % 32);
                default: ;
            endcase
            model_q.push_back(64'(a) * 64'(b));
            run_op(a, b, lat, prod);
            expv = model_q.pop_front();
            checks++;
            if (prod !== expv) begin
                failures++;
                if (bad_prod++ < 5)
                    $display("FAIL b2b_product_%0d a=%h b=%h got=%h want=%h", i, a, b, prod, expv);
            end
            checks++;
            if (lat !== 32) begin
                failures++;
                if (bad_lat++ < 5) $display("FAIL b2b_latency_%0d got=%0d want=32", i, lat);
            end
            checks++;
            if (accept_cyc - prev_accept < DW + 2) begin
                failures++;
                if (bad_gap++ < 5)
                    $display("FAIL b2b_spacing_%0d got=%0d want>=%0d", i, accept_cyc - prev_accept, DW + 2);
            end
            prev_accept = accept_cyc;
        end
        tick();
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got rdy=%b vld=%b want rdy=1 vld=0", req_ready, resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
